// File: rtl/adc_scan_avg.sv
// adc_scan_avg: round-robin LTC2308 channel scanner with boxcar averaging, valid/ready output and readback register file
module adc_scan_avg #(
  parameter int NUM_CH = 8,
  parameter int FRAME_CYCLES = 16,
  parameter int AVG_LOG2 = 2,
  parameter int DISCARD_FRAMES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  input  logic [11:0] result,
  output logic [2:0]  chan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_chan,
  output logic [11:0] out_data,
  output logic        overrun,
  input  logic [2:0]  rd_chan,
  output logic [11:0] rd_data
);
  localparam int FW = FRAME_CYCLES > 1 ? $clog2(FRAME_CYCLES) : 1;
  localparam int DW = $clog2(DISCARD_FRAMES + 1) > 0 ? $clog2(DISCARD_FRAMES + 1) : 1;
  localparam int SW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int AW = 12 + AVG_LOG2;
  typedef enum logic [1:0] {IDLE, DISCARD, ACCUM, PUBLISH} state_t;
  state_t state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [DW-1:0] disc_q, disc_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [2:0] chan_q, chan_d, out_chan_q, out_chan_d;
  logic out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic [11:0] out_data_q, out_data_d;
  logic [11:0] rf_q [8];
  logic [11:0] rf_d [8];
  logic [7:0] mask;
  logic mask_empty, tick, hv;
  logic [2:0] hi, lo, nxt;
  logic [11:0] avg;
  assign mask = ch_mask & 8'((9'd1 << NUM_CH) - 9'd1);
  assign mask_empty = mask == 8'd0;
  assign tick = fcnt_q == FW'(FRAME_CYCLES - 1);
  assign avg = 12'(acc_q >> AVG_LOG2);
  always_comb begin
    hv = 1'b0;
    hi = chan_q;
    lo = chan_q;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && 3'(i) > chan_q) begin
        hv = 1'b1;
        hi = 3'(i);
      end
      if (mask[i]) lo = 3'(i);
    end
    nxt = hv ? hi : lo;
  end
  always_comb begin
    state_d = state_q;
    fcnt_d = (state_q == IDLE || tick) ? '0 : fcnt_q + 1'b1;
    disc_d = disc_q;
    samp_d = samp_q;
    acc_d = acc_q;
    chan_d = chan_q;
    out_valid_d = out_valid_q && !out_ready;
    out_chan_d = out_chan_q;
    out_data_d = out_data_q;
    overrun_d = overrun_q;
    rf_d = rf_q;
    if (state_q != IDLE && !enable) begin
      state_d = IDLE;
      acc_d = '0;
    end else begin
      case (state_q)
        IDLE: if (enable && !mask_empty) begin
          state_d = DISCARD;
          disc_d = DW'(DISCARD_FRAMES);
          acc_d = '0;
        end
        DISCARD: if (tick) begin
          disc_d = disc_q - 1'b1;
          if (disc_q == DW'(1)) begin
            state_d = ACCUM;
            samp_d = '0;
          end
        end
        ACCUM: if (tick) begin
          acc_d = acc_q + AW'(result);
          samp_d = samp_q + 1'b1;
          if (samp_q == SW'((1 << AVG_LOG2) - 1)) state_d = PUBLISH;
        end
        default: begin
          rf_d[chan_q] = avg;
          out_data_d = avg;
          out_chan_d = chan_q;
          out_valid_d = 1'b1;
          overrun_d = overrun_q || (out_valid_q && !out_ready);
          chan_d = nxt;
          acc_d = '0;
          disc_d = DW'(DISCARD_FRAMES);
          state_d = mask_empty ? IDLE : DISCARD;
        end
      endcase
    end
    if (state_d == IDLE) fcnt_d = '0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      fcnt_q <= '0;
      disc_q <= '0;
      samp_q <= '0;
      acc_q <= '0;
      chan_q <= '0;
      out_valid_q <= 1'b0;
      out_chan_q <= '0;
      out_data_q <= '0;
      overrun_q <= 1'b0;
      rf_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      fcnt_q <= fcnt_d;
      disc_q <= disc_d;
      samp_q <= samp_d;
      acc_q <= acc_d;
      chan_q <= chan_d;
      out_valid_q <= out_valid_d;
      out_chan_q <= out_chan_d;
      out_data_q <= out_data_d;
      overrun_q <= overrun_d;
      rf_q <= rf_d;
    end
  end
  assign chan = chan_q;
  assign out_valid = out_valid_q;
  assign out_chan = out_chan_q;
  assign out_data = out_data_q;
  assign overrun = overrun_q;
  assign rd_data = (int'(rd_chan) < NUM_CH) ? rf_q[rd_chan] : '0;
endmodule

// File: tb/tb_adc_scan_avg.sv
// tb_adc_scan_avg: directed vector table plus multi-cycle sequences for adc_scan_avg
module tb_adc_scan_avg;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] ch_mask = 8'd0;
  logic [11:0] result = 12'd0;
  logic [2:0] rd_chan = 3'd0;
  logic [2:0] chan, out_chan;
  logic out_valid, overrun;
  logic [11:0] out_data, rd_data;
  int tests = 0;
  int fails = 0;
  int t = 0;
  int n = 0;
  logic [11:0] fv [64];
  typedef struct packed {
    logic [7:0] mask;
    logic [4:0][11:0] f;
    logic [2:0] echan;
    logic [11:0] edata;
    logic [2:0] enext;
  } vec_t;
  vec_t vec [6];
  always #5 clk = ~clk;
  adc_scan_avg dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .ch_mask(ch_mask),
    .result(result),
    .chan(chan),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_chan(out_chan),
    .out_data(out_data),
    .overrun(overrun),
    .rd_chan(rd_chan),
    .rd_data(rd_data)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask
  task automatic rd_chk(input string name, input logic [2:0] c, input logic [11:0] exp);
    rd_chan = c;
    #1;
    chk(name, 32'(rd_data), 32'(exp));
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    t++;
    result = (t / 16 < 64) ? fv[t / 16] : 12'd0;
  endtask
  task automatic run_to(input int target);
    while (t < target) step();
  endtask
  task automatic start();
    enable = 1'b1;
    @(posedge clk);
    #1;
    t = 0;
    result = fv[0];
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 64; k++) fv[k] = 12'd0;
    step();
    step();
    reset_n = 1'b1;
  endtask
  task automatic set_vec(input int i, input logic [7:0] m, input logic [11:0] f0, input logic [11:0] f1,
                         input logic [11:0] f2, input logic [11:0] f3, input logic [11:0] f4,
                         input logic [2:0] ec, input logic [11:0] ed, input logic [2:0] en);
    vec[i].mask = m;
    vec[i].f[0] = f0;
    vec[i].f[1] = f1;
    vec[i].f[2] = f2;
    vec[i].f[3] = f3;
    vec[i].f[4] = f4;
    vec[i].echan = ec;
    vec[i].edata = ed;
    vec[i].enext = en;
  endtask
  initial begin
    set_vec(0, 8'h01, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 3'd0, 12'h800, 3'd0);
    set_vec(1, 8'h01, 12'hFFF, 12'h001, 12'h002, 12'h002, 12'h002, 3'd0, 12'h001, 3'd0);
    set_vec(2, 8'h10, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 3'd0, 12'hFFF, 3'd4);
    set_vec(3, 8'h01, 12'h000, 12'h003, 12'h000, 12'h000, 12'h000, 3'd0, 12'h000, 3'd0);
    set_vec(4, 8'h01, 12'h000, 12'h100, 12'h200, 12'h300, 12'h400, 3'd0, 12'h280, 3'd0);
    set_vec(5, 8'hFF, 12'h005, 12'h001, 12'h001, 12'h001, 12'h002, 3'd0, 12'h001, 3'd1);
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_chan", 32'(chan), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rd_chk("rst_rd0", 3'd0, 12'h000);
    for (int v = 0; v < 6; v++) begin
      do_reset();
      ch_mask = vec[v].mask;
      for (int k = 0; k < 5; k++) fv[k] = vec[v].f[k];
      start();
      run_to(80);
      chk("vec_pre_valid", 32'(out_valid), 32'd0);
      step();
      chk("vec_valid", 32'(out_valid), 32'd1);
      chk("vec_out_chan", 32'(out_chan), 32'(vec[v].echan));
      chk("vec_out_data", 32'(out_data), 32'(vec[v].edata));
      chk("vec_next_chan", 32'(chan), 32'(vec[v].enext));
      rd_chk("vec_rd", vec[v].echan, vec[v].edata);
    end
    do_reset();
    ch_mask = 8'h81;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) fv[k] = 12'h100;
    for (int k = 5; k < 10; k++) fv[k] = 12'h700;
    for (int k = 10; k < 15; k++) fv[k] = 12'h100;
    start();
    run_to(81);
    chk("wrap1_valid", 32'(out_valid), 32'd1);
    chk("wrap1_chan", 32'(out_chan), 32'd0);
    chk("wrap1_data", 32'(out_data), 32'h100);
    chk("wrap1_next", 32'(chan), 32'd7);
    step();
    chk("wrap_taken", 32'(out_valid), 32'd0);
    run_to(161);
    chk("wrap2_chan", 32'(out_chan), 32'd7);
    chk("wrap2_data", 32'(out_data), 32'h700);
    chk("wrap2_next", 32'(chan), 32'd0);
    run_to(241);
    chk("wrap3_valid", 32'(out_valid), 32'd1);
    chk("wrap3_chan", 32'(out_chan), 32'd0);
    chk("wrap3_data", 32'(out_data), 32'h100);
    chk("wrap3_next", 32'(chan), 32'd7);
    rd_chk("wrap_rd7", 3'd7, 12'h700);
    rd_chk("wrap_rd0", 3'd0, 12'h100);
    do_reset();
    ch_mask = 8'h01;
    for (int k = 0; k < 5; k++) fv[k] = 12'h123;
    for (int k = 5; k < 10; k++) fv[k] = 12'h456;
    start();
    run_to(81);
    chk("bp1_data", 32'(out_data), 32'h123);
    chk("bp1_overrun", 32'(overrun), 32'd0);
    run_to(161);
    chk("bp2_valid", 32'(out_valid), 32'd1);
    chk("bp2_data", 32'(out_data), 32'h456);
    chk("bp2_overrun", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_drop_valid", 32'(out_valid), 32'd0);
    chk("bp_sticky", 32'(overrun), 32'd1);
    do_reset();
    ch_mask = 8'h01;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) fv[k] = 12'h200;
    for (int k = 5; k < 10; k++) fv[k] = 12'h300;
    start();
    run_to(81);
    chk("en_first_data", 32'(out_data), 32'h200);
    run_to(130);
    enable = 1'b0;
    step();
    chk("en_chan_held", 32'(chan), 32'd0);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (out_valid) n++;
    end
    chk("en_no_publish", 32'(n), 32'd0);
    rd_chk("en_rf_kept", 3'd0, 12'h200);
    fv[0] = 12'hFFF;
    for (int k = 1; k < 5; k++) fv[k] = 12'h010;
    start();
    run_to(80);
    chk("reen_pre_valid", 32'(out_valid), 32'd0);
    step();
    chk("reen_valid", 32'(out_valid), 32'd1);
    chk("reen_data", 32'(out_data), 32'h010);
    chk("reen_chan", 32'(out_chan), 32'd0);
    do_reset();
    ch_mask = 8'h01;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) fv[k] = 12'h0AB;
    start();
    run_to(40);
    ch_mask = 8'h00;
    run_to(81);
    chk("empty_pub_valid", 32'(out_valid), 32'd1);
    chk("empty_pub_data", 32'(out_data), 32'h0AB);
    step();
    n = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (out_valid) n++;
    end
    chk("empty_idle", 32'(n), 32'd0);
    chk("empty_chan", 32'(chan), 32'd0);
    do_reset();
    ch_mask = 8'h81;
    for (int k = 0; k < 5; k++) fv[k] = 12'h555;
    start();
    run_to(81);
    chk("mid_pub_data", 32'(out_data), 32'h555);
    run_to(120);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_chan", 32'(chan), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    rd_chk("mid_rst_rd0", 3'd0, 12'h000);
    ch_mask = 8'h00;
    enable = 1'b1;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (out_valid || chan != 3'd0) n++;
    end
    chk("mask0_quiet", 32'(n), 32'd0);
    rd_chk("mask0_rd0", 3'd0, 12'h000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
